// File: rtl/fetch_decode_queue.sv
// rtl/fetch_decode_queue.sv - in-order {pc, insn} buffer between fetch and decode
//
// Purpose:
//   Captures fetched {pc, insn} pairs via a valid/ready handshake.
//   Holds up to DEPTH entries in order.
//   Presents the oldest entry to decode, first-word-fall-through, from
//   registered outputs.
//   Flush discards every buffered entry on a control-flow redirect.
//
// Ports:
//   clk          in   clock, all state updates on posedge
//   reset        in   asynchronous active-low reset (0 = in reset)
//   f_valid_i    in   fetch presents a valid {pc, insn}
//   f_pc_i       in   fetched PC
//   f_insn_i     in   fetched instruction
//   f_ready_o    out  queue can accept this cycle (registered state only)
//   flush_i      in   discard all entries
//   d_valid_o    out  head entry valid for decode
//   d_pc_o       out  head entry PC
//   d_insn_o     out  head entry instruction
//   d_misalign_o out  head entry PC[1:0] != 0
//   d_ready_i    in   decode consumes head this cycle
//   count_o      out  current occupancy

module fetch_decode_queue #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       f_valid_i,
    input  logic [AWIDTH-1:0]          f_pc_i,
    input  logic [DWIDTH-1:0]          f_insn_i,
    output logic                       f_ready_o,
    input  logic                       flush_i,
    output logic                       d_valid_o,
    output logic [AWIDTH-1:0]          d_pc_o,
    output logic [DWIDTH-1:0]          d_insn_o,
    output logic                       d_misalign_o,
    input  logic                       d_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AWIDTH-1:0] pc_mem   [DEPTH];
    logic [DWIDTH-1:0] insn_mem [DEPTH];

    logic [PW-1:0] rd_ptr, wr_ptr, rd_nxt, wr_nxt;
    logic [CW-1:0] count, count_nxt;
    logic          accept_en;
    logic          push, pop;

    logic [AWIDTH-1:0] head_pc_nxt;
    logic [DWIDTH-1:0] head_insn_nxt;

    // accept_en keeps f_ready_o low while reset is held and raises it on the
    // first edge after release, independent of occupancy.
    assign f_ready_o = accept_en && (count != FULL);
    assign d_valid_o = (count != '0);
    assign count_o   = count;

    assign push = f_valid_i && f_ready_o && !flush_i;
    assign pop  = d_valid_o && d_ready_i && !flush_i;

    always_comb begin
        rd_nxt    = rd_ptr;
        wr_nxt    = wr_ptr;
        count_nxt = count;
        if (flush_i) begin
            rd_nxt    = wr_ptr;
            count_nxt = '0;
        end else begin
            if (push) wr_nxt = wr_ptr + PW'(1);
            if (pop)  rd_nxt = rd_ptr + PW'(1);
            if (push && !pop)      count_nxt = count + CW'(1);
            else if (pop && !push) count_nxt = count - CW'(1);
        end
    end

    // Head registers are loaded with whatever will sit at rd_nxt after this
    // edge. If that slot is being written right now, the new entry is the head
    // (only possible when it lands as the sole / next visible entry), so take
    // it from the inputs; otherwise read storage.
    always_comb begin
        head_pc_nxt   = d_pc_o;
        head_insn_nxt = d_insn_o;
        if (count_nxt != '0) begin
            if (push && (wr_ptr == rd_nxt)) begin
                head_pc_nxt   = f_pc_i;
                head_insn_nxt = f_insn_i;
            end else begin
                head_pc_nxt   = pc_mem[rd_nxt];
                head_insn_nxt = insn_mem[rd_nxt];
            end
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= f_pc_i;
            insn_mem[wr_ptr] <= f_insn_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            accept_en    <= 1'b0;
            d_pc_o       <= '0;
            d_insn_o     <= '0;
            d_misalign_o <= 1'b0;
        end else begin
            rd_ptr       <= rd_nxt;
            wr_ptr       <= wr_nxt;
            count        <= count_nxt;
            accept_en    <= 1'b1;
            d_pc_o       <= head_pc_nxt;
            d_insn_o     <= head_insn_nxt;
            d_misalign_o <= (head_pc_nxt[1:0] != 2'b00);
        end
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb/tb_fetch_decode_queue.sv - self-checking bench for fetch_decode_queue
module tb_fetch_decode_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        f_valid_i = 1'b0;
    logic [31:0] f_pc_i = '0;
    logic [31:0] f_insn_i = '0;
    logic        f_ready_o;
    logic        flush_i = 1'b0;
    logic        d_valid_o;
    logic [31:0] d_pc_o;
    logic [31:0] d_insn_o;
    logic        d_misalign_o;
    logic        d_ready_i = 1'b0;
    logic [2:0]  count_o;

    fetch_decode_queue #(.DWIDTH(32), .AWIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .f_valid_i(f_valid_i), .f_pc_i(f_pc_i), .f_insn_i(f_insn_i), .f_ready_o(f_ready_o),
        .flush_i(flush_i),
        .d_valid_o(d_valid_o), .d_pc_o(d_pc_o), .d_insn_o(d_insn_o),
        .d_misalign_o(d_misalign_o), .d_ready_i(d_ready_i), .count_o(count_o)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: ordered list of {pc, insn}, plus last presented head.
    logic [63:0] mq[$];
    logic [63:0] last_head = '0;
    bit          m_rdy = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".count"},    64'(count_o),      64'(mq.size()));
        check({tag, ".d_valid"},  64'(d_valid_o),    64'(mq.size() != 0));
        check({tag, ".f_ready"},  64'(f_ready_o),    64'(m_rdy && (mq.size() != DEPTH)));
        check({tag, ".d_pc"},     64'(d_pc_o),       64'(last_head[63:32]));
        check({tag, ".d_insn"},   64'(d_insn_o),     64'(last_head[31:0]));
        check({tag, ".misalign"}, 64'(d_misalign_o), 64'(last_head[33:32] != 2'b00));
    endtask

    // Drive one cycle of inputs (called at negedge), advance the model across
    // the posedge, then compare at the following negedge.
    task automatic step(input string tag, input logic fv, input logic [31:0] pc,
                        input logic [31:0] insn, input logic dr, input logic fl);
        bit do_push, do_pop;
        f_valid_i = fv; f_pc_i = pc; f_insn_i = insn; d_ready_i = dr; flush_i = fl;
        do_push = fv && m_rdy && (mq.size() != DEPTH) && !fl;
        do_pop  = (mq.size() != 0) && dr && !fl;
        @(posedge clk);
        if (fl) mq.delete();
        else begin
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back({pc, insn});
        end
        m_rdy = 1;
        if (mq.size() != 0) last_head = mq[0];
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) step("drain", 1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        // 1 reset held three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs("reset_hold");
        reset = 1'b1;
        step("reset_release", 1'b0, '0, '0, 1'b0, 1'b0);

        // 2 streaming with decode always ready
        for (int i = 0; i < 3; i++)
            step("stream", 1'b1, 32'h0100_0000 + 32'(4*i), 32'hA000_0000 + 32'(i), 1'b1, 1'b0);
        drain();

        // 3 full / stall: five offered, four accepted, then four pops in order
        for (int i = 0; i < 5; i++)
            step("fill", 1'b1, 32'h0100_0000 + 32'(4*i), 32'hB000_0000 + 32'(i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            step("unload", 1'b0, '0, '0, 1'b1, 1'b0);

        // 4 PC wrap across a pointer wrap
        for (int i = 0; i < 3; i++)
            step("wrap_pre", 1'b1, 32'h0200_0000 + 32'(4*i), 32'hC000_0000 + 32'(i), 1'b1, 1'b0);
        step("wrap_a", 1'b1, 32'hFFFF_FFFC, 32'hC0DE_0001, 1'b0, 1'b0);
        step("wrap_b", 1'b1, 32'h0000_0000, 32'hC0DE_0002, 1'b0, 1'b0);
        drain();

        // 5 flush at count 3 with a concurrent push
        for (int i = 0; i < 3; i++)
            step("pre_flush", 1'b1, 32'h0100_0010 + 32'(4*i), 32'hD000_0000 + 32'(i), 1'b0, 1'b0);
        step("flush", 1'b1, 32'h0100_0030, 32'hDEAD_0000, 1'b1, 1'b1);
        step("post_flush", 1'b1, 32'h0100_0040, 32'hD000_0040, 1'b0, 1'b0);
        drain();

        // 6 misaligned PC, then asynchronous reset between edges
        step("misalign", 1'b1, 32'h0100_0002, 32'hE000_0002, 1'b0, 1'b0);
        step("misalign2", 1'b1, 32'h0100_0008, 32'hE000_0008, 1'b0, 1'b0);
        f_valid_i = 1'b0;
        #2 reset = 1'b0;
        #1;
        mq.delete(); m_rdy = 0; last_head = '0;
        check_outputs("async_reset");
        @(negedge clk);
        check_outputs("async_reset_hold");
        reset = 1'b1;
        step("async_release", 1'b0, '0, '0, 1'b0, 1'b0);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] pc;
            pc = $urandom;
            if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
            step("rand", 1'($urandom_range(0, 1)), pc, $urandom,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
